// File: rtl/range_pkg.sv
// Shared types and defaults for the range-finder sequence driver.
package range_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, LAST} seq_state_e;
endpackage

// File: rtl/range_seq_buf.sv
// Sample buffer: register file with an append pointer, a sticky drop flag and an async read port.
module range_seq_buf
  import range_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             lock,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic             clear_ok;
  logic             wr_ok;

  // clear and writes are both frozen while a sequence is being replayed
  assign clear_ok = clear && !lock;
  assign wr_ok    = wr_en && !full && !lock && !clear_ok;
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear_ok) begin
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (wr_ok) begin
        count <= count + 1'b1;
        full  <= (count == (AW+1)'(DEPTH - 1));
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[count[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/range_seq_driver.sv
// Replays the buffered samples as a go/data/finish sequence and reports its max-min range.
module range_seq_driver
  import range_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow,
  output logic             start_err,
  output logic [WIDTH-1:0] exp_range
);
  seq_state_e       state, state_nx;
  logic [AW:0]      n;
  logic [AW:0]      n_m1;
  logic [AW:0]      idx;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] mx, mn;
  logic             start_rej;

  function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] smin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  range_seq_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clear    (clear),
    .lock     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  assign n_m1      = n - 1'b1;
  assign start_rej = (state == IDLE) && start && (clear || (count == '0));

  // rd_addr always points at the sample that the next registered cycle will present
  always_comb begin
    state_nx = state;
    rd_addr  = '0;
    case (state)
      IDLE: begin
        if (start && !clear && (count != '0)) state_nx = FIRST;
      end
      FIRST: begin
        if (n > (AW+1)'(2)) begin
          state_nx = STREAM;
          rd_addr  = idx[AW-1:0];
        end else begin
          state_nx = LAST;
          rd_addr  = n_m1[AW-1:0];
        end
      end
      STREAM: begin
        if (idx == n_m1) begin
          state_nx = LAST;
          rd_addr  = n_m1[AW-1:0];
        end else begin
          rd_addr  = idx[AW-1:0];
        end
      end
      LAST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n         <= '0;
      idx       <= '0;
      mx        <= '0;
      mn        <= '0;
      data_out  <= '0;
      go        <= 1'b0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      exp_range <= '0;
    end else begin
      state     <= state_nx;
      go        <= 1'b0;
      finish    <= 1'b0;
      done      <= 1'b0;
      start_err <= start_rej;
      if (state == IDLE && state_nx == FIRST) begin
        n        <= count;
        idx      <= (AW+1)'(1);
        go       <= 1'b1;
        busy     <= 1'b1;
        data_out <= rd_data;
        mx       <= rd_data;
        mn       <= rd_data;
      end else if (state_nx == STREAM) begin
        idx      <= idx + 1'b1;
        data_out <= rd_data;
        mx       <= smax(mx, rd_data);
        mn       <= smin(mn, rd_data);
      end else if (state_nx == LAST) begin
        finish   <= 1'b1;
        data_out <= rd_data;
        mx       <= smax(mx, rd_data);
        mn       <= smin(mn, rd_data);
      end else if (state == LAST) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        exp_range <= mx - mn;
      end
    end
  end
endmodule
